memory_bank: RTL and testbench
==============================

# memory_bank

Byte-addressable RV32I data memory used by the load/store stage of the core. It performs synchronous stores of byte, halfword and word size with byte-lane masking. It performs combinational loads with RV32I sign or zero extension selected by the instruction's funct3. Contents are cleared by reset.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two.
- clk  input  1  clock; all stores occur on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clock clk.
- read_en  input  1  load enable; gates read_data.
- write_en  input  1  store enable.
- address  input  32  byte address.
- write_data  input  32  store data; the LSBs are used for SB/SH.
- funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- read_data  output  32  extended load result.

## Operation
- Storage is DEPTH_WORDS little-endian 32-bit words.
- Word index is address[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Lane selection:
  - Byte accesses select the lane with address[1:0].
  - Halfword accesses select the lane pair with address[1]; address[0] is ignored.
  - Word accesses ignore address[1:0].
- Stores, performed when write_en=1 at posedge clk:
  - 000 SB: write_data[7:0] goes to byte lane address[1:0].
  - 001 SH: write_data[15:0] goes to bytes {address[1],1'b0}..+1.
  - 010 SW: the full word is written.
  - Any other funct3: no memory change.
  - Lanes not selected keep their contents.
- Loads, combinational while read_en=1:
  - 000 LB: the selected byte, sign-extended.
  - 100 LBU: the selected byte, zero-extended.
  - 001 LH: the selected halfword, sign-extended.
  - 101 LHU: the selected halfword, zero-extended.
  - 010 LW: the full word.
  - 011, 110, 111: read_data=0.
- read_en=0 forces read_data=0.
- Reset behaviour:
  - While rst=0, all words are cleared to 0 asynchronously and stores are blocked.
  - read_data evaluates the cleared array, so it is 0.
- Simultaneous read_en and write_en:
  - The store commits at the edge.
  - Before the edge, read_data shows the pre-store contents.
  - After the edge, read_data shows the updated contents.

## Timing
- Store latency: one edge. Data is visible on a load of the same address immediately after the posedge where write_en=1.
- Load latency: zero cycles, purely combinational from address, funct3, read_en and memory state. There is no registered output.
- No handshake or ready signal; every access completes in its cycle.
- Reset assertion takes effect without a clock edge.
- Release is synchronous to use: the first store can occur on the first posedge after rst rises.
- Reset asserted mid-store (same cycle as write_en): the store is discarded and memory reads 0.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release. LW at 0x0 and at 0x4 must both return 0x00000000. read_en=0 must give 0.
- SW 0x11223344 @0x4, then LW @0x4 -> 0x11223344. Then SB 0x000000AA @0x5, LW @0x4 -> 0x1122AA44.
- SH 0x0000BEEF @0x6, then LW @0x4 -> 0xBEEFAA44. Lanes 0 and 1 must be untouched.
- Extension:
  - LB @0x5 -> 0xFFFFFFAA; LBU @0x5 -> 0x000000AA.
  - LH @0x4 -> 0xFFFFAA44; LHU @0x4 -> 0x0000AA44.
  - LH @0x6 -> 0xFFFFBEEF.
- Edge cases:
  - SW @0x4 with funct3=011 -> no change.
  - LW @(0x4 + 4*DEPTH_WORDS) aliases to 0x4.
  - Load funct3=110 -> 0.
- Simultaneous access: read_en=write_en=1, SW 0xCAFEF00D @0x8 over 0. read_data must be 0 before the edge and 0xCAFEF00D after. Asserting rst mid-sequence must clear all values.

Source files
------------

// File: rtl/memory_bank.sv
// Byte-addressable RV32I data memory: synchronous masked stores (SB/SH/SW) and
// combinational loads with funct3-selected sign or zero extension.
module memory_bank #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read_en,
   input  logic        write_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [2:0]  funct3,
   output logic [31:0] read_data
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic [3:0]    wr_mask;
   logic [31:0]   wr_lanes;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;

   // Upper address bits are ignored so accesses wrap modulo the array size.
   logic unused_addr;
   assign unused_addr = ^address[31:AW+2];

   assign word_idx = address[AW+1:2];

   // NOTE: always_comb gives every output a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      wr_mask  = 4'b0000;
      wr_lanes = write_data;
      case (funct3)
         F3_B: begin
            wr_mask  = 4'b0001 << address[1:0];
            wr_lanes = {4{write_data[7:0]}};
         end
         F3_H: begin
            wr_mask  = address[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{write_data[15:0]}};
         end
         F3_W: wr_mask = 4'b1111;
         default: wr_mask = 4'b0000;
      endcase
   end

   // NOTE: the array is cleared by the async reset because the load path must read zero while rst is low; this forces flops instead of a RAM macro.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (write_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
               mem_q[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word = mem_q[word_idx];
      rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];
      case (address[1:0])
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
   end

   always_comb begin
      read_data = '0;
      if (read_en) begin
         case (funct3)
            F3_B:    read_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   read_data = {24'd0, rd_byte};
            F3_H:    read_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   read_data = {16'd0, rd_half};
            F3_W:    read_data = rd_word;
            default: read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank: stores, extended loads, aliasing, illegal
// funct3, simultaneous read/write and asynchronous reset clearing.
module tb_memory_bank;

   localparam int DEPTH_WORDS = 256;

   logic        clk;
   logic        rst;
   logic        read_en;
   logic        write_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [2:0]  funct3;
   logic [31:0] read_data;

   int checks;
   int errors;

   memory_bank #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .read_en    (read_en),
      .write_en   (write_en),
      .address    (address),
      .write_data (write_data),
      .funct3     (funct3),
      .read_data  (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
      @(negedge clk);
      read_en    = 1'b0;
      write_en   = 1'b1;
      address    = addr;
      write_data = data;
      funct3     = f3;
      @(posedge clk);
      #1;
      write_en   = 1'b0;
   endtask

   task automatic load_check(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] exp);
      @(negedge clk);
      read_en  = 1'b1;
      write_en = 1'b0;
      address  = addr;
      funct3   = f3;
      #1;
      check(tag, read_data, exp);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      read_en    = 1'b0;
      write_en   = 1'b0;
      address    = '0;
      write_data = '0;
      funct3     = 3'b010;

      // Store attempted while reset is held must be blocked.
      @(negedge clk);
      write_en   = 1'b1;
      address    = 32'h0;
      write_data = 32'hDEADBEEF;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      write_en = 1'b0;
      rst      = 1'b1;

      load_check("rst_lw0", 32'h0, 3'b010, 32'h0);
      load_check("rst_lw4", 32'h4, 3'b010, 32'h0);
      @(negedge clk);
      read_en = 1'b0;
      #1;
      check("rd_en_off", read_data, 32'h0);

      store(32'h4, 32'h11223344, 3'b010);
      load_check("sw_lw4", 32'h4, 3'b010, 32'h11223344);
      @(negedge clk);
      read_en = 1'b0;
      #1;
      check("rd_en_off_data", read_data, 32'h0);
      store(32'h5, 32'h000000AA, 3'b000);
      load_check("sb_lw4", 32'h4, 3'b010, 32'h1122AA44);
      store(32'h6, 32'h0000BEEF, 3'b001);
      load_check("sh_lw4", 32'h4, 3'b010, 32'hBEEFAA44);

      load_check("lb5",  32'h5, 3'b000, 32'hFFFFFFAA);
      load_check("lbu5", 32'h5, 3'b100, 32'h000000AA);
      load_check("lb4",  32'h4, 3'b000, 32'h00000044);
      load_check("lb7",  32'h7, 3'b000, 32'hFFFFFFBE);
      load_check("lh4",  32'h4, 3'b001, 32'hFFFFAA44);
      load_check("lhu4", 32'h4, 3'b101, 32'h0000AA44);
      load_check("lh6",  32'h6, 3'b001, 32'hFFFFBEEF);
      load_check("lhu7", 32'h7, 3'b101, 32'h0000BEEF);
      load_check("lw7",  32'h7, 3'b010, 32'hBEEFAA44);

      store(32'h4, 32'hDEADBEEF, 3'b011);
      load_check("sw_f3_011", 32'h4, 3'b010, 32'hBEEFAA44);
      store(32'h4, 32'hDEADBEEF, 3'b100);
      load_check("sw_f3_100", 32'h4, 3'b010, 32'hBEEFAA44);
      load_check("alias_lw", 32'h4 + 4*DEPTH_WORDS, 3'b010, 32'hBEEFAA44);
      store(32'h0 + 4*DEPTH_WORDS, 32'h00000055, 3'b000);
      load_check("alias_sb", 32'h0, 3'b010, 32'h00000055);
      load_check("ld_f3_110", 32'h4, 3'b110, 32'h0);
      load_check("ld_f3_011", 32'h4, 3'b011, 32'h0);
      load_check("ld_f3_111", 32'h4, 3'b111, 32'h0);

      // Simultaneous read and write: pre-store value before the edge, new value after.
      @(negedge clk);
      read_en    = 1'b1;
      write_en   = 1'b1;
      address    = 32'h8;
      write_data = 32'hCAFEF00D;
      funct3     = 3'b010;
      #1;
      check("rw_before", read_data, 32'h0);
      @(posedge clk);
      #1;
      write_en = 1'b0;
      check("rw_after", read_data, 32'hCAFEF00D);

      // Reset asserted mid-store: store discarded and whole array cleared.
      @(negedge clk);
      read_en    = 1'b1;
      write_en   = 1'b1;
      address    = 32'hC;
      write_data = 32'h12345678;
      funct3     = 3'b010;
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_c", read_data, 32'h0);
      @(posedge clk);
      #1;
      check("rst_mid_c_edge", read_data, 32'h0);
      @(negedge clk);
      write_en = 1'b0;
      rst      = 1'b1;
      load_check("rst_clr_8", 32'h8, 3'b010, 32'h0);
      load_check("rst_clr_4", 32'h4, 3'b010, 32'h0);
      load_check("rst_clr_0", 32'h0, 3'b010, 32'h0);
      load_check("rst_clr_c", 32'hC, 3'b010, 32'h0);

      store(32'h10, 32'hA5A55A5A, 3'b010);
      load_check("post_rst_sw", 32'h10, 3'b010, 32'hA5A55A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
